// File: rtl/wbu_regfile.sv
// Write-back stage: in-order result queue draining one entry per cycle into the integer
// register file, with two combinational read ports that forward from pending entries.
module wbu_regfile #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int QDEPTH         = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_valid_i,
  output logic                      wb_ready_o,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
  input  logic [DATA_WIDTH-1:0]     wb_val_i,
  input  logic                      wb_en_i,
  input  logic                      wb_stall_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  output logic [DATA_WIDTH-1:0]     rs1_val_o,
  output logic [DATA_WIDTH-1:0]     rs2_val_o,
  output logic                      q_empty_o,
  output logic                      retire_o,
  output logic [63:0]               retire_cnt_o
);

  localparam int PW   = $clog2(QDEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]     regs  [NREG];
  logic [REG_ADDR_WIDTH-1:0] q_rd  [QDEPTH];
  logic [DATA_WIDTH-1:0]     q_val [QDEPTH];
  logic                      q_en  [QDEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          enq;
  logic          deq;

  // Ready looks only at the registered count, so a full queue never accepts even if draining.
  assign wb_ready_o = (count < CW'(QDEPTH));
  assign q_empty_o  = (count == '0);
  assign enq        = wb_valid_i && wb_ready_o;
  assign deq        = (count != '0) && !wb_stall_i;

  always_ff @(posedge clk) begin
    if (enq) begin
      q_rd[tail]  <= wb_rd_i;
      q_val[tail] <= wb_val_i;
      q_en[tail]  <= wb_en_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      retire_o     <= 1'b0;
      retire_cnt_o <= '0;
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) begin
        head         <= head + 1'b1;
        retire_cnt_o <= retire_cnt_o + 64'd1;
        if (q_en[head] && (q_rd[head] != '0)) regs[q_rd[head]] <= q_val[head];
      end
      retire_o <= deq;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Walk oldest to youngest so the youngest matching entry wins.
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [REG_ADDR_WIDTH-1:0] addr);
    logic [PW-1:0] idx;
    read_port = regs[addr];
    for (int i = 0; i < QDEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && q_en[idx] && (q_rd[idx] == addr)) read_port = q_val[idx];
    end
    if (addr == '0) read_port = '0;
  endfunction

  always_comb begin
    rs1_val_o = read_port(rs1_addr_i);
    rs2_val_o = read_port(rs2_addr_i);
  end

endmodule
